// File: rtl/dram_resp.sv
// dram_resp: data-memory responder for the pipelined RV32I core.
//   The target end of the EX-stage DRAM interface. Holds a word-organised RAM,
//   commits byte/half/word-lane stores and returns a registered full word to
//   MEM, which does its own sign/zero extension. After every reset a
//   sequencer zeroes the whole array before any access is honoured.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   dram_adr      byte address from EX; word index = adr[ADDR_WIDTH+1:2]
//   dram_w_op     store width: 00 word, 01 half, 10 byte, 11 reserved
//   dram_we       store request (already qualified by the sender)
//   dram_wdin     right-aligned store data
//   dram_rdout    registered read word for the previous cycle's address
//   init_done     high once the clear sequence has finished
//   misalign_err  sticky flag: a misaligned or reserved-width store was seen
//   err_adr       dram_adr of the first erroneous store
//   store_cnt     committed store count, wraps modulo 2**32
module dram_resp #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dram_adr,
    input  logic [1:0]  dram_w_op,
    input  logic        dram_we,
    input  logic [31:0] dram_wdin,
    output logic [31:0] dram_rdout,
    output logic        init_done,
    output logic        misalign_err,
    output logic [31:0] err_adr,
    output logic [31:0] store_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            lane;
    logic                  bad;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  commit;
    logic                  err_store;
    logic                  clr_wr;

    assign widx = dram_adr[ADDR_WIDTH+1:2];
    assign lane = dram_adr[1:0];

    // Store decode: byte enables, lane-replicated data and the alignment check.
    always_comb begin
        bad   = 1'b0;
        be    = 4'b0000;
        wdata = dram_wdin;
        unique case (dram_w_op)
            2'b00: begin
                bad = (lane != 2'b00);
                be  = 4'b1111;
            end
            2'b01: begin
                bad   = lane[0];
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{dram_wdin[15:0]}};
            end
            2'b10: begin
                be    = 4'b0001 << lane;
                wdata = {4{dram_wdin[7:0]}};
            end
            default: bad = 1'b1;
        endcase
    end

    // Accesses are only honoured in RUN; rst suppresses any commit at its edge.
    assign commit    = !rst && (state == S_RUN) && dram_we && !bad;
    assign err_store = !rst && (state == S_RUN) && dram_we && bad;
    assign clr_wr    = (state == S_CLEAR);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_CLEAR;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_idx == '1) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Clear index and the done flag, which rises on the edge that writes the
    // last word so init_done is low for exactly DEPTH cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx   <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
            if (state == S_CLEAR && state_nxt == S_RUN) init_done <= 1'b1;
        end
    end

    // Array: one write port shared between the clear sequencer and stores.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_idx] <= '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Read-first: the nonblocking read samples the pre-store word.
    always_ff @(posedge clk) begin
        if (rst || state != S_RUN) dram_rdout <= '0;
        else                       dram_rdout <= mem[widx];
    end

    // Error capture and store counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
            err_adr      <= '0;
            store_cnt    <= '0;
        end else begin
            if (commit) store_cnt <= store_cnt + 32'd1;
            if (err_store) begin
                misalign_err <= 1'b1;
                if (!misalign_err) err_adr <= dram_adr;
            end
        end
    end

endmodule

// File: tb/tb_dram_resp.sv
// tb_dram_resp: directed + randomized bench for dram_resp (ADDR_WIDTH=4).
module tb_dram_resp;

    localparam int AW = 4;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dram_adr;
    logic [1:0]  dram_w_op;
    logic        dram_we;
    logic [31:0] dram_wdin;
    logic [31:0] dram_rdout;
    logic        init_done;
    logic        misalign_err;
    logic [31:0] err_adr;
    logic [31:0] store_cnt;

    int checks = 0;
    int failures = 0;

    dram_resp #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dram_adr     (dram_adr),
        .dram_w_op    (dram_w_op),
        .dram_we      (dram_we),
        .dram_wdin    (dram_wdin),
        .dram_rdout   (dram_rdout),
        .init_done    (init_done),
        .misalign_err (misalign_err),
        .err_adr      (err_adr),
        .store_cnt    (store_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: memory image plus expected outputs.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd;
    logic        m_init;
    logic        m_err;
    logic [31:0] m_eadr;
    logic [31:0] m_cnt;
    int          m_clr_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input bit r, input bit we, input logic [1:0] op,
                                       input logic [31:0] adr, input logic [31:0] wd);
        int idx;
        bit ok;
        if (r) begin
            m_rd = 0; m_init = 0; m_err = 0; m_eadr = 0; m_cnt = 0;
            m_clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        end else if (m_clr_left > 0) begin
            m_rd = 0;
            m_clr_left--;
            m_init = (m_clr_left == 0);
        end else begin
            idx  = (adr / 4) % DEPTH;
            m_rd = m_mem[idx];
            if (we) begin
                ok = (op == 2'd0 && adr % 4 == 0) || (op == 2'd1 && adr % 2 == 0) || (op == 2'd2);
                if (ok) begin
                    case (op)
                        2'd0: m_mem[idx] = wd;
                        2'd1: m_mem[idx][(adr % 4) * 8 +: 16] = wd[15:0];
                        default: m_mem[idx][(adr % 4) * 8 +: 8] = wd[7:0];
                    endcase
                    m_cnt++;
                end else begin
                    if (!m_err) m_eadr = adr;
                    m_err = 1;
                end
            end
        end
    endfunction

    // One clock: drive, clock, update model, compare all outputs.
    task automatic step(input bit r, input bit we, input logic [1:0] op,
                        input logic [31:0] adr, input logic [31:0] wd);
        rst = r; dram_we = we; dram_w_op = op; dram_adr = adr; dram_wdin = wd;
        @(posedge clk);
        model_edge(r, we, op, adr, wd);
        #1;
        chk("rdout", dram_rdout, m_rd);
        chk("init_done", {31'd0, init_done}, {31'd0, m_init});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        chk("err_adr", err_adr, m_eadr);
        chk("store_cnt", store_cnt, m_cnt);
    endtask

    task automatic rd(input logic [31:0] adr);
        step(0, 0, 2'd0, adr, 32'd0);
    endtask

    // Count cycles until init_done rises, optionally with stores that must drop.
    task automatic clear_len(input bit with_stores, input string tag);
        int n = 0;
        for (int k = 0; k < 4 * DEPTH && !init_done; k++) begin
            step(0, with_stores, 2'($urandom_range(0, 2)), $urandom & 32'hFC, $urandom);
            n++;
        end
        chk(tag, n, DEPTH);
    endtask

    task automatic rand_run(input int n);
        for (int k = 0; k < n; k++)
            step(0, 1'($urandom), 2'($urandom), $urandom_range(0, 255), $urandom);
    endtask

    initial begin
        rst = 1; dram_we = 0; dram_w_op = 0; dram_adr = 0; dram_wdin = 0;
        m_clr_left = DEPTH;

        // Reset for 2 cycles, then clear length and all-zero contents.
        step(1, 0, 2'd0, 32'd0, 32'd0);
        step(1, 1, 2'd0, 32'd0, 32'hFFFF_FFFF);
        chk("rst_init", {31'd0, init_done}, 32'd0);
        clear_len(0, "clear_len_first");
        for (int i = 0; i < DEPTH; i++) begin
            rd(i * 4);
            chk("zero_after_clear", dram_rdout, 32'd0);
        end

        // Lane merges.
        step(0, 1, 2'd0, 32'h08, 32'h1122_3344);
        rd(32'h08); chk("sw_rd", dram_rdout, 32'h1122_3344);
        step(0, 1, 2'd2, 32'h09, 32'hFFFF_FFAA);
        rd(32'h08); chk("sb_rd", dram_rdout, 32'h1122_AA44);
        step(0, 1, 2'd1, 32'h0A, 32'h1234_BEEF);
        rd(32'h08); chk("sh_rd", dram_rdout, 32'hBEEF_AA44);
        chk("cnt3", store_cnt, 32'd3);

        // Read-first on a same-cycle store.
        step(0, 1, 2'd0, 32'h04, 32'hDEAD_BEEF);
        chk("read_first_old", dram_rdout, 32'd0);
        rd(32'h04); chk("read_first_new", dram_rdout, 32'hDEAD_BEEF);

        // Error stores: nothing written, first address sticks.
        step(0, 1, 2'd1, 32'h05, 32'h0000_5555);
        step(0, 1, 2'd0, 32'h0E, 32'h7777_7777);
        step(0, 1, 2'd3, 32'h00, 32'h9999_9999);
        chk("err_flag", {31'd0, misalign_err}, 32'd1);
        chk("err_adr_first", err_adr, 32'h05);
        chk("err_cnt", store_cnt, 32'd4);
        rd(32'h04); chk("err_nowr_04", dram_rdout, 32'hDEAD_BEEF);
        rd(32'h0C); chk("err_nowr_0c", dram_rdout, 32'd0);
        rd(32'h00); chk("err_nowr_00", dram_rdout, 32'd0);

        // Aliasing modulo DEPTH*4.
        step(0, 1, 2'd0, 32'h40, 32'h1234_5678);
        rd(32'h00); chk("alias", dram_rdout, 32'h1234_5678);

        rand_run(300);

        // Reset mid-RUN, then again mid-CLEAR at index 5, stores dropped.
        step(1, 1, 2'd0, 32'h00, 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) step(0, 1, 2'd0, k * 4, 32'hA5A5_A5A5);
        chk("midclear_init", {31'd0, init_done}, 32'd0);
        step(1, 0, 2'd0, 32'h00, 32'd0);
        clear_len(1, "clear_len_restart");
        chk("cnt_after_clear", store_cnt, 32'd0);
        chk("err_after_clear", {31'd0, misalign_err}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i * 4);
            chk("zero_after_reclear", dram_rdout, 32'd0);
        end

        rand_run(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_resp.md
Name: dram_resp

Overview:
- Data-memory responder for the pipelined RV32I core; the target end of the EX-stage DRAM interface (dram_adr, dram_w_op, dram_we, dram_wdin).
- Holds a word-organised RAM and commits byte-, half- and word-lane stores.
- Returns a registered full-word read to the MEM stage, which performs sign/zero extension itself.
- Contains a post-reset clear sequencer, misalignment detection and a committed-store counter.

Parameters:
ADDR_WIDTH, 14, word-index bits; depth = 2**ADDR_WIDTH words (default 64 KiB).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
dram_adr  in  32  byte address from EX (ALU result)
dram_w_op  in  2  store width: 00 word, 01 half, 10 byte, 11 reserved
dram_we  in  1  store request; already qualified with ex_valid by the sender
dram_wdin  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
dram_rdout  out  32  registered read word for the address of the previous cycle
init_done  out  1  high once the clear sequence has finished
misalign_err  out  1  sticky error flag for a misaligned or reserved store
err_adr  out  32  dram_adr of the first erroneous store
store_cnt  out  32  number of committed stores; wraps modulo 2**32

Behaviour:
- Reset (rst=1 at an edge):
  - dram_rdout=0, init_done=0, misalign_err=0, err_adr=0, store_cnt=0.
  - FSM goes to CLEAR; clear index=0.
  - Applies identically mid-CLEAR (index restarts at 0) and mid-RUN (array is cleared again).
- FSM states:
  - CLEAR:
    - Each cycle writes 0 to word[index] and increments index.
    - After writing index DEPTH-1: go to RUN and set init_done=1 at that same edge.
    - Clear takes exactly DEPTH cycles after reset deasserts.
  - RUN: terminal until rst.
- During CLEAR:
  - dram_we is ignored: no write, no error, no count.
  - dram_rdout holds 0.
- Word index = dram_adr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH*4.
- Read (RUN only):
  - dram_rdout <= word[index] every cycle, regardless of dram_we.
  - Latency is one cycle.
  - Read-first: if a store hits the same word in the same cycle, dram_rdout shows the pre-store contents. The next cycle's read sees the new data.
- Store commit (RUN, dram_we=1), at the same edge:
  - w_op=00: requires adr[1:0]=00; writes all 4 lanes with wdin.
  - w_op=01: requires adr[0]=0; writes wdin[15:0] into lanes {adr[1],0} and {adr[1],1}.
  - w_op=10: any alignment; writes wdin[7:0] into lane adr[1:0].
  - Lanes not selected keep their value.
  - A committed store increments store_cnt by 1.
- Error store (RUN, dram_we=1, alignment requirement violated or w_op=11):
  - No array write; store_cnt unchanged.
  - misalign_err <= 1.
  - If misalign_err was 0, err_adr <= dram_adr. Later errors do not overwrite err_adr.
  - Only rst clears misalign_err.
- There is no back-pressure; one access is accepted per cycle.
- Back-to-back stores to the same word in consecutive cycles both commit, in order.

Test Plan:
- ADDR_WIDTH=4, pulse rst for 2 cycles -> init_done low for exactly 16 cycles after rst falls, then high. Reading every word 0x00..0x3C -> dram_rdout=0 one cycle after each address.
- SW 0x11223344 @0x08, then SB 0xAA @0x09, then SH 0xBEEF @0x0A -> a read of 0x08 returns 0x11223344, then 0x1122AA44, then 0xBEEFAA44; store_cnt=3.
- Same cycle: SW 0xDEADBEEF @0x04 while reading 0x04 (old value 0) -> next cycle dram_rdout=0. The following cycle's read of 0x04 gives 0xDEADBEEF.
- SH @0x05, then SW @0x0E, then w_op=11 @0x00 -> no word changes; store_cnt unchanged; misalign_err=1; err_adr=0x00000005.
- Aliasing with ADDR_WIDTH=4: SW 0x12345678 @0x40 -> read of 0x00 returns 0x12345678.
- rst asserted mid-RUN after writes, and again mid-CLEAR at index 5 -> each time the counter restarts and init_done stays low for 16 cycles. Afterwards all words read 0, store_cnt=0 and misalign_err=0. Stores issued during CLEAR are dropped (store_cnt stays 0).
